uart_apb_master: RTL and testbench
==================================

# uart_apb_master

APB3 initiator for the fabric UART register block. It accepts single register-access commands on a valid/ready port and runs each as a SETUP/ACCESS APB transfer, inserting wait states while PREADY is low. It returns the read data and the error status on a one-cycle response strobe. It sits between fabric control logic (a command sequencer or a soft controller) and the APB slave port of the UART.

## Interface
Parameters:
- ADDR_WIDTH, default 5: width of PADDR and CMD_ADDR.
- DATA_WIDTH, default 8: width of PWDATA, PRDATA, CMD_WDATA and RSP_RDATA.
- TIMEOUT_CYCLES, default 255, legal range 1 to 65535: the maximum number of consecutive ACCESS cycles with PREADY low. Used only when timeout support is compiled in.

Ports (one clock; reset is asynchronous and active-low):
- PCLK, input, 1: system clock. All logic is on the rising edge.
- PRESETN, input, 1: asynchronous active-low reset.
- CMD_VALID, input, 1: a command is presented.
- CMD_READY, output, 1: the block accepts a command.
- CMD_WRITE, input, 1: 1 = write, 0 = read.
- CMD_ADDR, input, ADDR_WIDTH: register byte address.
- CMD_WDATA, input, DATA_WIDTH: write data.
- RSP_VALID, output, 1: one-cycle completion strobe.
- RSP_RDATA, output, DATA_WIDTH: read data. It is 0 for writes and for timeouts.
- RSP_ERR, output, 1: the slave error was sampled, or a timeout occurred.
- RSP_TIMEOUT, output, 1: the transfer was aborted by the timeout.
- PSEL, output, 1; PENABLE, output, 1; PWRITE, output, 1; PADDR, output, ADDR_WIDTH; PWDATA, output, DATA_WIDTH: APB request signals.
- PRDATA, input, DATA_WIDTH; PREADY, input, 1; PSLVERR, input, 1: APB response signals.

## Operation
- State machine states: IDLE, SETUP, ACCESS.
- IDLE:
  - CMD_READY = 1.
  - CMD_VALID & CMD_READY latches CMD_WRITE, CMD_ADDR and CMD_WDATA into PWRITE, PADDR and PWDATA. The state goes to SETUP.
- SETUP: PSEL = 1 and PENABLE = 0. The state unconditionally goes to ACCESS.
- ACCESS:
  - PSEL = 1 and PENABLE = 1.
  - PREADY = 1 completes the transfer. The block samples PRDATA (for reads) and PSLVERR, and the state returns to IDLE.
  - PREADY = 0 keeps the state in ACCESS.
- Response outputs:
  - RSP_VALID is registered. It is high for exactly one cycle: the cycle after completion.
  - RSP_RDATA, RSP_ERR and RSP_TIMEOUT hold their values until the next completion.
- PADDR, PWDATA and PWRITE:
  - They are stable from SETUP through the end of ACCESS.
  - They keep their last value in IDLE. They do not return to 0.
- All outputs are registered. CMD_READY is decoded from the state register.
- Reset values:
  - State = IDLE.
  - CMD_READY = 1.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA = 0.
  - RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT = 0.
  - Wait counter = 0.
- Reset asserted mid-transfer: PSEL and PENABLE drop immediately (asynchronously). The command is lost and no response is generated.
- CMD_VALID outside IDLE is ignored because CMD_READY = 0. The command does not need to be held stable outside the handshake cycle.

## Timing
- Command accepted in cycle N:
  - SETUP in cycle N+1.
  - First ACCESS cycle in N+2.
  - With zero wait states, RSP_VALID = 1 and CMD_READY = 1 in cycle N+3.
- Each PREADY-low cycle adds one ACCESS cycle and one cycle of latency.
- Back-to-back throughput: one transfer every 3 cycles. A new command may be accepted in the same cycle that RSP_VALID is high.
- Wait counter:
  - Cleared on entry to ACCESS.
  - Increments in each ACCESS cycle with PREADY = 0.
  - Width is clog2(TIMEOUT_CYCLES+1) bits.
  - It saturates and does not wrap.

## Configuration
- Macro: UART_APB_MASTER_TIMEOUT_EN.
- Defined:
  - If PREADY is low in TIMEOUT_CYCLES consecutive ACCESS cycles, the transfer is aborted at the end of the last of those cycles. PSEL and PENABLE are 0 in the next cycle, and the state returns to IDLE.
  - The response in that next cycle is RSP_VALID = 1, RSP_TIMEOUT = 1, RSP_ERR = 1, RSP_RDATA = 0.
  - If PREADY is 1 in the cycle that would otherwise time out, normal completion wins.
- Undefined:
  - No counter logic is built.
  - ACCESS waits indefinitely for PREADY.
  - RSP_TIMEOUT is tied to 0.

## Test plan
- Write, zero wait states: CMD write, address 0x08, data 0x1A, accepted in cycle 0, with PREADY = 1.
  - Expected: PSEL = 1 in cycles 1-2; PENABLE = 1 in cycle 2; PADDR = 0x08 and PWDATA = 0x1A in cycles 1-2.
  - Expected in cycle 3: RSP_VALID = 1, RSP_ERR = 0, RSP_RDATA = 0x00.
- Read: read of address 0x10, with the slave returning PRDATA = 0x05 in ACCESS.
  - Expected: RSP_RDATA = 0x05 with RSP_VALID, and RSP_ERR = 0.
- Wait states: PREADY held low for 3 ACCESS cycles, then high.
  - Expected: 4 ACCESS cycles, with PADDR and PWDATA stable throughout.
  - Expected: RSP_VALID 6 cycles after acceptance.
- Slave error: PSLVERR = 1 together with PREADY = 1.
  - Expected: RSP_ERR = 1 and RSP_TIMEOUT = 0.
- Timeout: TIMEOUT_CYCLES = 4 and PREADY stuck at 0.
  - With the macro defined: abort after 4 ACCESS cycles; RSP_TIMEOUT = 1, RSP_ERR = 1, RSP_RDATA = 0x00.
  - With the macro undefined: the block is still in ACCESS after 100 cycles.
- Reset mid-transfer: PRESETN is asserted during ACCESS.
  - Expected: PSEL and PENABLE are 0 immediately, and all outputs are at their reset values.
  - Expected after release: CMD_READY = 1 and no RSP_VALID.

Source files
------------

// File: rtl/uart_apb_master.sv
// uart_apb_master
// APB3 initiator for the fabric UART register block. Takes one register
// command at a time on a valid/ready port, runs it as a SETUP/ACCESS
// transfer (wait states while PREADY is low) and reports the result on a
// one-cycle response strobe with held read data and error flags.
//
// Optional feature: define UART_APB_MASTER_TIMEOUT_EN to abort an ACCESS
// phase after TIMEOUT_CYCLES consecutive PREADY-low cycles. Without it no
// counter is built, ACCESS waits forever and RSP_TIMEOUT stays 0.
module uart_apb_master #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [DATA_WIDTH-1:0] CMD_WDATA,
    output logic                  RSP_VALID,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic                  RSP_ERR,
    output logic                  RSP_TIMEOUT,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    psel_r;
    logic                    penable_r;
    logic                    pwrite_r;
    logic [ADDR_WIDTH-1:0]   paddr_r;
    logic [DATA_WIDTH-1:0]   pwdata_r;
    logic                    rsp_valid_r;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r;
    logic                    rsp_err_r;
    logic                    rsp_timeout_r;
    logic                    accept_s;
    logic                    done_s;
    logic                    abort_s;

    assign accept_s = (state_r == IDLE) && CMD_VALID;
    assign done_s   = (state_r == ACCESS) && PREADY;

`ifdef UART_APB_MASTER_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_r;

    // Wait counter: cleared on the way into ACCESS, counts PREADY-low ACCESS cycles, saturating.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            wait_cnt_r <= '0;
        end else if (state_r == SETUP) begin
            wait_cnt_r <= '0;
        end else if ((state_r == ACCESS) && !PREADY && (wait_cnt_r != CNT_MAX)) begin
            wait_cnt_r <= wait_cnt_r + CNT_ONE;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // The current cycle is the TIMEOUT_CYCLES-th low one when the count already holds one less.
    assign abort_s = (state_r == ACCESS) && !PREADY && (wait_cnt_r == CNT_LAST);
`else
    assign abort_s = 1'b0;
`endif

    // Next-state decode for the IDLE/SETUP/ACCESS sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (CMD_VALID) begin
                    state_next_s = SETUP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SETUP: begin
                state_next_s = ACCESS;
            end
            ACCESS: begin
                if (done_s || abort_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = ACCESS;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register plus PSEL/PENABLE registered from the next state so they line up with it.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_r   <= IDLE;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            psel_r    <= (state_next_s != IDLE);
            penable_r <= (state_next_s == ACCESS);
        end
    end

    // Capture the command on handshake; held through the transfer and afterwards in IDLE.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            pwrite_r <= 1'b0;
            paddr_r  <= '0;
            pwdata_r <= '0;
        end else if (accept_s) begin
            pwrite_r <= CMD_WRITE;
            paddr_r  <= CMD_ADDR;
            pwdata_r <= CMD_WDATA;
        end else begin
            pwrite_r <= pwrite_r;
            paddr_r  <= paddr_r;
            pwdata_r <= pwdata_r;
        end
    end

    // Response: one-cycle strobe after completion; data and flags hold until the next one.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= '0;
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else if (done_s) begin
            rsp_valid_r   <= 1'b1;
            rsp_rdata_r   <= pwrite_r ? '0 : PRDATA;
            rsp_err_r     <= PSLVERR;
            rsp_timeout_r <= 1'b0;
        end else if (abort_s) begin
            rsp_valid_r   <= 1'b1;
            rsp_rdata_r   <= '0;
            rsp_err_r     <= 1'b1;
            rsp_timeout_r <= 1'b1;
        end else begin
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= rsp_rdata_r;
            rsp_err_r     <= rsp_err_r;
            rsp_timeout_r <= rsp_timeout_r;
        end
    end

    assign CMD_READY   = (state_r == IDLE);
    assign PSEL        = psel_r;
    assign PENABLE     = penable_r;
    assign PWRITE      = pwrite_r;
    assign PADDR       = paddr_r;
    assign PWDATA      = pwdata_r;
    assign RSP_VALID   = rsp_valid_r;
    assign RSP_RDATA   = rsp_rdata_r;
    assign RSP_ERR     = rsp_err_r;
    assign RSP_TIMEOUT = rsp_timeout_r;

endmodule

// File: tb/tb_uart_apb_master.sv
// Self-checking bench for uart_apb_master. A transaction-level model
// (acceptance cycle + ACCESS length) predicts every output on every cycle;
// directed transfers pin the model with literal expectations, then a
// randomized run covers wait states, errors, back-to-back and ignored commands.
module tb_uart_apb_master;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int TO = 4;
`ifdef UART_APB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          PCLK;
    logic          PRESETN;
    logic          CMD_VALID;
    logic          CMD_READY;
    logic          CMD_WRITE;
    logic [AW-1:0] CMD_ADDR;
    logic [DW-1:0] CMD_WDATA;
    logic          RSP_VALID;
    logic [DW-1:0] RSP_RDATA;
    logic          RSP_ERR;
    logic          RSP_TIMEOUT;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    uart_apb_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK       (PCLK),
        .PRESETN    (PRESETN),
        .CMD_VALID  (CMD_VALID),
        .CMD_READY  (CMD_READY),
        .CMD_WRITE  (CMD_WRITE),
        .CMD_ADDR   (CMD_ADDR),
        .CMD_WDATA  (CMD_WDATA),
        .RSP_VALID  (RSP_VALID),
        .RSP_RDATA  (RSP_RDATA),
        .RSP_ERR    (RSP_ERR),
        .RSP_TIMEOUT(RSP_TIMEOUT),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;
    bit in_reset = 1'b1;

    // Transaction-level model: current command, previous request values, pending/held response.
    bit            have_txn;
    int            acc_cyc;
    int            txn_len;
    int            txn_wait;
    logic          txn_write;
    logic [AW-1:0] txn_addr;
    logic [DW-1:0] txn_wdata;
    logic          old_write;
    logic [AW-1:0] old_addr;
    logic [DW-1:0] old_wdata;
    int            rsp_due;
    logic [DW-1:0] pend_rdata;
    logic          pend_err;
    logic          pend_to;
    logic [DW-1:0] hold_rdata;
    logic          hold_err;
    logic          hold_to;
    bit            f_en;
    logic [DW-1:0] f_rd;
    logic          f_err;

    function automatic bit exp_busy();
        return have_txn && ((cyc - acc_cyc) >= 1) && ((cyc - acc_cyc) <= 1 + txn_len);
    endfunction

    function automatic bit exp_access();
        return have_txn && ((cyc - acc_cyc) >= 2) && ((cyc - acc_cyc) <= 1 + txn_len);
    endfunction

    function automatic bit exp_new();
        return have_txn && (cyc > acc_cyc);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge PCLK) begin
        if (chk_en && !in_reset) begin
            check("cmd_ready",   32'(CMD_READY),   32'(!exp_busy()));
            check("psel",        32'(PSEL),        32'(exp_busy()));
            check("penable",     32'(PENABLE),     32'(exp_access()));
            check("pwrite",      32'(PWRITE),      32'(exp_new() ? txn_write : old_write));
            check("paddr",       32'(PADDR),       32'(exp_new() ? txn_addr : old_addr));
            check("pwdata",      32'(PWDATA),      32'(exp_new() ? txn_wdata : old_wdata));
            check("rsp_valid",   32'(RSP_VALID),   32'(cyc == rsp_due));
            check("rsp_rdata",   32'(RSP_RDATA),   32'(hold_rdata));
            check("rsp_err",     32'(RSP_ERR),     32'(hold_err));
            check("rsp_timeout", 32'(RSP_TIMEOUT), 32'(hold_to));
        end
    end

    task automatic clear_model();
        have_txn   = 1'b0;
        acc_cyc    = 0;
        txn_len    = 0;
        txn_wait   = 0;
        txn_write  = 1'b0;
        txn_addr   = '0;
        txn_wdata  = '0;
        old_write  = 1'b0;
        old_addr   = '0;
        old_wdata  = '0;
        rsp_due    = -1;
        pend_rdata = '0;
        pend_err   = 1'b0;
        pend_to    = 1'b0;
        hold_rdata = '0;
        hold_err   = 1'b0;
        hold_to    = 1'b0;
        f_en       = 1'b0;
    endtask

    // Slave side and command noise for the current cycle; records the response to come.
    task automatic drive_slave();
        int d;
        d       = cyc - acc_cyc;
        PRDATA  = DW'($urandom);
        PSLVERR = 1'($urandom);
        PREADY  = 1'($urandom);
        if (exp_busy()) begin
            CMD_VALID = 1'($urandom);
            CMD_WRITE = 1'($urandom);
            CMD_ADDR  = AW'($urandom);
            CMD_WDATA = DW'($urandom);
        end
        if (exp_access()) begin
            PREADY = (d - 2 == txn_wait);
            if (d == 1 + txn_len) begin
                rsp_due = cyc + 1;
                if (d - 2 == txn_wait) begin
                    if (f_en) begin
                        PRDATA  = f_rd;
                        PSLVERR = f_err;
                    end
                    pend_rdata = txn_write ? '0 : PRDATA;
                    pend_err   = PSLVERR;
                    pend_to    = 1'b0;
                end else begin
                    pend_rdata = '0;
                    pend_err   = 1'b1;
                    pend_to    = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
        cyc++;
        CMD_VALID = 1'b0;
        if (cyc == rsp_due) begin
            hold_rdata = pend_rdata;
            hold_err   = pend_err;
            hold_to    = pend_to;
        end
        drive_slave();
    endtask

    // Present a command in the current (idle) cycle; w = PREADY-low cycles before completion.
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int w, input bit fe, input logic [DW-1:0] frd, input logic fer);
        if (have_txn) begin
            old_write = txn_write;
            old_addr  = txn_addr;
            old_wdata = txn_wdata;
        end
        have_txn  = 1'b1;
        acc_cyc   = cyc;
        txn_wait  = w;
        txn_len   = (TO_EN && (w >= TO)) ? TO : w + 1;
        txn_write = wr;
        txn_addr  = a;
        txn_wdata = wd;
        f_en      = fe;
        f_rd      = frd;
        f_err     = fer;
        CMD_VALID = 1'b1;
        CMD_WRITE = wr;
        CMD_ADDR  = a;
        CMD_WDATA = wd;
    endtask

    task automatic wait_model_rsp();
        int guard;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!((cyc == rsp_due) && (rsp_due > acc_cyc)) && guard < 2000);
    endtask

    task automatic wait_dut_rsp(output int n, output int nacc);
        n    = 0;
        nacc = 0;
        do begin
            tick();
            n++;
            if (PENABLE === 1'b1) nacc++;
        end while (RSP_VALID !== 1'b1 && n < 40);
        check("rsp_seen", 32'(RSP_VALID), 32'd1);
    endtask

    task automatic check_reset_vals();
        check("rst_cmd_ready", 32'(CMD_READY),   32'd1);
        check("rst_psel",      32'(PSEL),        32'd0);
        check("rst_penable",   32'(PENABLE),     32'd0);
        check("rst_pwrite",    32'(PWRITE),      32'd0);
        check("rst_paddr",     32'(PADDR),       32'd0);
        check("rst_pwdata",    32'(PWDATA),      32'd0);
        check("rst_rsp_valid", 32'(RSP_VALID),   32'd0);
        check("rst_rsp_rdata", 32'(RSP_RDATA),   32'd0);
        check("rst_rsp_err",   32'(RSP_ERR),     32'd0);
        check("rst_rsp_to",    32'(RSP_TIMEOUT), 32'd0);
    endtask

    // Assert reset between edges, check it took effect at once, then release.
    task automatic reset_mid();
        #2;
        PRESETN  = 1'b0;
        in_reset = 1'b1;
        #1;
        check_reset_vals();
        clear_model();
        tick();
        tick();
        PRESETN  = 1'b1;
        in_reset = 1'b0;
        repeat (3) begin
            tick();
            check("post_rst_ready", 32'(CMD_READY), 32'd1);
            check("post_rst_valid", 32'(RSP_VALID), 32'd0);
        end
    endtask

    initial begin
        int n;
        int nacc;
        PRESETN   = 1'b0;
        CMD_VALID = 1'b0;
        CMD_WRITE = 1'b0;
        CMD_ADDR  = '0;
        CMD_WDATA = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        clear_model();
        repeat (2) @(posedge PCLK);
        #1;
        check_reset_vals();
        PRESETN  = 1'b1;
        in_reset = 1'b0;
        chk_en   = 1'b1;
        tick();

        // Write 0x1A to 0x08, no wait states.
        issue(1'b1, 5'h08, 8'h1A, 0, 1'b1, 8'hEE, 1'b0);
        tick();
        check("w_setup_psel",  32'(PSEL),    32'd1);
        check("w_setup_pen",   32'(PENABLE), 32'd0);
        check("w_setup_paddr", 32'(PADDR),   32'h08);
        check("w_setup_pwd",   32'(PWDATA),  32'h1A);
        tick();
        check("w_acc_pen",     32'(PENABLE), 32'd1);
        check("w_acc_paddr",   32'(PADDR),   32'h08);
        tick();
        check("w_rsp_valid",   32'(RSP_VALID), 32'd1);
        check("w_rsp_ready",   32'(CMD_READY), 32'd1);
        check("w_rsp_rdata",   32'(RSP_RDATA), 32'h00);
        check("w_rsp_err",     32'(RSP_ERR),   32'd0);

        // Read of 0x10, back-to-back with the write response.
        issue(1'b0, 5'h10, 8'h77, 0, 1'b1, 8'h05, 1'b0);
        wait_dut_rsp(n, nacc);
        check("r_latency", 32'(n), 32'd3);
        check("r_rdata",   32'(RSP_RDATA), 32'h05);
        check("r_err",     32'(RSP_ERR),   32'd0);

        // Three wait states.
        issue(1'b1, 5'h04, 8'hC3, 3, 1'b1, 8'h00, 1'b0);
        wait_dut_rsp(n, nacc);
        check("ws_latency", 32'(n),    32'd6);
        check("ws_access",  32'(nacc), 32'd4);

        // Slave error on a read.
        issue(1'b0, 5'h0C, 8'h00, 1, 1'b1, 8'h5A, 1'b1);
        wait_dut_rsp(n, nacc);
        check("se_err",   32'(RSP_ERR),     32'd1);
        check("se_to",    32'(RSP_TIMEOUT), 32'd0);
        check("se_rdata", 32'(RSP_RDATA),   32'h5A);
        tick();

        // PREADY stuck low.
        issue(1'b0, 5'h03, 8'h00, 1000, 1'b0, 8'h00, 1'b0);
`ifdef UART_APB_MASTER_TIMEOUT_EN
        wait_dut_rsp(n, nacc);
        check("to_latency", 32'(n),           32'd6);
        check("to_access",  32'(nacc),        32'd4);
        check("to_flag",    32'(RSP_TIMEOUT), 32'd1);
        check("to_err",     32'(RSP_ERR),     32'd1);
        check("to_rdata",   32'(RSP_RDATA),   32'h00);
        tick();
        check("to_psel",    32'(PSEL),        32'd0);
`else
        repeat (100) tick();
        check("stuck_psel",  32'(PSEL),      32'd1);
        check("stuck_pen",   32'(PENABLE),   32'd1);
        check("stuck_ready", 32'(CMD_READY), 32'd0);
        reset_mid();
`endif

        // Reset in the middle of an ACCESS phase with PREADY low.
        tick();
        issue(1'b1, 5'h1F, 8'hA5, 2, 1'b0, 8'h00, 1'b0);
        repeat (3) tick();
        check("mid_psel", 32'(PSEL),    32'd1);
        check("mid_pen",  32'(PENABLE), 32'd1);
        reset_mid();

        // Randomized transfers: gaps 0..2 cycles, 0..5 wait states.
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            issue(1'($urandom), AW'($urandom), DW'($urandom), int'($urandom_range(0, 5)),
                  1'b0, 8'h00, 1'b0);
            wait_model_rsp();
        end
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
